bky_serial_loader: RTL
======================

# bky_serial_loader

Parametrised serial loader for Buckeye shift-register chains on the DCFEB. It buffers configuration words written from the CLK40 control domain in an internal FIFO. On START it streams them bit-serially to the Buckeye chain using a shift clock derived internally from CLK40, so a separate 1 MHz clock domain is not needed. It adds selectable bit order, back-to-back word streaming, abort, overflow reporting and a sent-word count.

## Interface
- DATA_W, 16: bits per word (2..64).
- DEPTH, 64: FIFO depth in words; power of 2, 4..1024.
- CLK_DIV, 40: CLK40 cycles per shift-clock period; even, ≥4.
- MSB_FIRST, 0: 0 = bit 0 shifted first; 1 = bit DATA_W-1 shifted first.

Ports:
- CLK40  in  1  system clock; everything is on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WR_EN  in  1  push WR_DATA into the FIFO.
- WR_DATA  in  DATA_W  word to load.
- START  in  1  one-cycle pulse; request transmission of FIFO contents.
- ABORT  in  1  one-cycle pulse; stop and flush.
- CLR_DONE  in  1  clears DONE and WR_ERR.
- SCLK  out  1  free-running shift clock.
- SHCK_ENA  out  1  shift-clock gate; high while bits are valid.
- SDATA  out  1  serial data.
- BUSY  out  1  high from START acceptance until return to IDLE.
- DONE  out  1  sticky; set on normal completion.
- WR_ERR  out  1  sticky; set by a write while the FIFO is full.
- FULL, EMPTY  out  1  FIFO flags.
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy.
- WORDS_SENT  out  16  words popped since last START; saturates at 16'hFFFF.

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 and free-runs from reset.
- SCLK = (div_cnt ≥ CLK_DIV/2).
- fall_tick is the cycle in which div_cnt = CLK_DIV-1. All serializer updates register on fall_tick, so SDATA changes with the SCLK falling edge and is stable at the rising edge.
- FIFO:
  - WR_EN with !FULL pushes the word.
  - WR_EN with FULL drops the word and sets WR_ERR.
  - A push and a pop in the same cycle leave COUNT unchanged.
  - Writes are allowed in every state.
- FSM states: IDLE, ARMED, SHIFT.
  - IDLE: START → ARMED, BUSY=1, WORDS_SENT cleared, DONE cleared. START while BUSY is ignored.
  - ARMED, on fall_tick:
    - If !EMPTY: pop a word into the shifter, bit_cnt = DATA_W-1, WORDS_SENT+1, → SHIFT.
    - If EMPTY: set DONE, → IDLE.
  - SHIFT, on fall_tick:
    - If bit_cnt ≠ 0: shift one position toward the output bit, bit_cnt−1.
    - If bit_cnt = 0 and !EMPTY: pop the next word with no gap cycle, WORDS_SENT+1.
    - If bit_cnt = 0 and EMPTY: set DONE, → IDLE.
- SHCK_ENA = (state = SHIFT).
- SDATA = shifter[0] (MSB_FIRST=0) or shifter[DATA_W-1] (MSB_FIRST=1), forced to 0 outside SHIFT.
- ABORT, any state, takes effect at the next CLK40 edge, not on fall_tick:
  - → IDLE, SHCK_ENA=0, BUSY=0.
  - FIFO flushed, COUNT=0.
  - DONE not set; WORDS_SENT holds.
  - A WR_EN in the ABORT cycle is discarded.
- CLR_DONE clears DONE and WR_ERR. If CLR_DONE and a DONE set occur in the same cycle, the set wins.

## Timing
- Reset values: SCLK=0, SHCK_ENA=0, SDATA=0, BUSY=0, DONE=0, WR_ERR=0, EMPTY=1, FULL=0, COUNT=0, WORDS_SENT=0, div_cnt=0, state=IDLE.
- A pushed word is visible in COUNT and EMPTY one cycle after WR_EN.
- START to first SHCK_ENA: from 1 to CLK_DIV+1 cycles, depending on divider phase.
- Per word: exactly DATA_W SCLK periods; consecutive words are contiguous.
- N words take N·DATA_W·CLK_DIV cycles from SHCK_ENA rise to fall.
- DONE and BUSY=0 occur in the same cycle that SHCK_ENA falls.
- A word written during SHIFT before the fall_tick that ends the current word is streamed in the same burst.

## Test plan
- Default params, write 16'hA5C3, START:
  - SHCK_ENA high for 640 cycles.
  - SDATA, sampled on SCLK rising edges, reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - DONE=1, WORDS_SENT=1.
- MSB_FIRST=1, DATA_W=8, three words 8'h81, 8'h7E, 8'hFF:
  - 24 contiguous bits 10000001 01111110 11111111.
  - SHCK_ENA has no gap; WORDS_SENT=3.
- START with FIFO empty: DONE set within CLK_DIV+1 cycles; SHCK_ENA stays 0; WORDS_SENT=0.
- Write DEPTH+2 words:
  - FULL=1, COUNT=DEPTH, WR_ERR=1.
  - CLR_DONE clears WR_ERR.
  - START streams exactly DEPTH words.
- ABORT mid-word of a 4-word burst:
  - Next cycle: SHCK_ENA=0, BUSY=0, COUNT=0, DONE=0.
  - A following START sets DONE with 0 words sent.
- RST_N asserted mid-SHIFT: every output takes its reset value immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bky_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : bky_serial_loader
// Purpose  : FIFO-buffered bit-serial loader for Buckeye shift-register chains,
//            shift clock divided down from CLK40.
// Revision : 1.0
// ============================================================================
module bky_serial_loader #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 64,
    parameter int CLK_DIV   = 40,
    parameter int MSB_FIRST = 0
) (
    input  logic                     CLK40,
    input  logic                     RST_N,
    input  logic                     WR_EN,
    input  logic [DATA_W-1:0]        WR_DATA,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic                     CLR_DONE,
    output logic                     SCLK,
    output logic                     SHCK_ENA,
    output logic                     SDATA,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     WR_ERR,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [15:0]              WORDS_SENT
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_DIV_W  = $clog2(CLK_DIV);
    localparam int c_BIT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_DIV_W-1:0]    r_div_cnt;
    logic                  r_sclk;
    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_ADDR_W:0]     r_count;
    logic [DATA_W-1:0]     r_shifter;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic                  r_shck_ena;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_err;
    logic [15:0]           r_words_sent;

    logic                  w_fall_tick;
    logic [c_DIV_W-1:0]    w_div_next;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_word_end;
    logic                  w_done_set;
    logic                  w_start_acc;
    logic [DATA_W-1:0]     w_rd_data;
    logic [DATA_W-1:0]     w_shift_next;
    logic                  w_out_bit;

    // ---------------- shift-clock divider ----------------
    assign w_fall_tick = (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
    assign w_div_next  = w_fall_tick ? '0 : r_div_cnt + c_DIV_W'(1);

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_sclk    <= (w_div_next >= c_DIV_W'(CLK_DIV / 2));
        end
    end

    // ---------------- FIFO ----------------
    assign w_full      = (r_count == (c_ADDR_W+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_rd_data   = r_mem[r_rd_ptr];
    assign w_push      = WR_EN && !w_full && !ABORT;
    // A word boundary is the fall_tick that leaves ARMED or finishes the last bit.
    assign w_word_end  = w_fall_tick && !ABORT &&
                         ((r_state == S_ARMED) ||
                          ((r_state == S_SHIFT) && (r_bit_cnt == '0)));
    assign w_pop       = w_word_end && !w_empty;
    assign w_done_set  = w_word_end && w_empty;
    assign w_start_acc = !ABORT && (r_state == S_IDLE) && START;

    always_ff @(posedge CLK40) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (ABORT) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- bit-order selection ----------------
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shifter[DATA_W-2:0], 1'b0};
            assign w_out_bit    = r_shifter[DATA_W-1];
        end else begin : g_lsb_first
            assign w_shift_next = {1'b0, r_shifter[DATA_W-1:1]};
            assign w_out_bit    = r_shifter[0];
        end
    endgenerate

    // ---------------- serializer FSM ----------------
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_shifter    <= '0;
            r_bit_cnt    <= '0;
            r_shck_ena   <= 1'b0;
            r_busy       <= 1'b0;
            r_words_sent <= '0;
        end else if (ABORT) begin
            r_state    <= S_IDLE;
            r_shck_ena <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state      <= S_ARMED;
                        r_busy       <= 1'b1;
                        r_words_sent <= '0;
                    end
                end
                S_ARMED, S_SHIFT: begin
                    if (w_fall_tick) begin
                        if ((r_state == S_SHIFT) && (r_bit_cnt != '0)) begin
                            r_shifter <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt - c_BIT_W'(1);
                        end else if (!w_empty) begin
                            r_state    <= S_SHIFT;
                            r_shck_ena <= 1'b1;
                            r_shifter  <= w_rd_data;
                            r_bit_cnt  <= c_BIT_W'(DATA_W - 1);
                            if (r_words_sent != 16'hFFFF) begin
                                r_words_sent <= r_words_sent + 16'd1;
                            end
                        end else begin
                            r_state    <= S_IDLE;
                            r_shck_ena <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_shck_ena <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as CLR_DONE wins.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (CLR_DONE || w_start_acc) begin
                r_done <= 1'b0;
            end
            if (WR_EN && w_full && !ABORT) begin
                r_wr_err <= 1'b1;
            end else if (CLR_DONE) begin
                r_wr_err <= 1'b0;
            end
        end
    end

    assign SCLK       = r_sclk;
    assign SHCK_ENA   = r_shck_ena;
    assign SDATA      = r_shck_ena & w_out_bit;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign WR_ERR     = r_wr_err;
    assign FULL       = w_full;
    assign EMPTY      = w_empty;
    assign COUNT      = r_count;
    assign WORDS_SENT = r_words_sent;

endmodule
`default_nettype wire
